// File: rtl/sm83_alu_nibble_seq_pkg.sv
// sm83_alu_pkg: shared types and constants for the sequenced SM83 ALU.
//   alu_op_t    - 5-bit ALU opcode as presented on the op port
//   alu_state_t - sequencer state (IDLE, LO nibble, HI nibble)
//   core_mode_t - function select for the shared 4-bit core
//   DAA_ADJ_LO / DAA_ADJ_HI - decimal-adjust correction constants
//   decode_op() - maps raw opcode bits to alu_op_t; unused codes become ADD
package sm83_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADC  = 5'd1,
        OP_SUB  = 5'd2,
        OP_SBC  = 5'd3,
        OP_AND  = 5'd4,
        OP_XOR  = 5'd5,
        OP_OR   = 5'd6,
        OP_CP   = 5'd7,
        OP_RLC  = 5'd8,
        OP_RRC  = 5'd9,
        OP_RL   = 5'd10,
        OP_RR   = 5'd11,
        OP_SLA  = 5'd12,
        OP_SRA  = 5'd13,
        OP_SRL  = 5'd14,
        OP_SWAP = 5'd15,
        OP_DAA  = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        CORE_ADD = 2'd0,
        CORE_AND = 2'd1,
        CORE_XOR = 2'd2,
        CORE_OR  = 2'd3
    } core_mode_t;

    localparam logic [5:0] DAA_ADJ_LO = 6'h06;
    localparam logic [7:0] DAA_ADJ_HI = 8'h60;

    function automatic alu_op_t decode_op(input logic [4:0] raw);
        return (raw > 5'd16) ? OP_ADD : alu_op_t'(raw);
    endfunction

endpackage

// File: rtl/sm83_alu_nibble_seq_if.sv
// sm83_alu_nibble_seq_if: request/response bundle of the sequenced ALU.
//   Request : start, op, a, b, carry_in, half_carry_in, neg_in
//   Response: busy, valid, result, result_we, zero_out, carry_out,
//             half_carry_out, sign_out, shift_out, daa_carry_out
//   Debug   : dbg_state (current sequencer state)
// Handshake: a request is taken on the rising clk edge where start=1 and
// busy=0; all request fields are captured on that edge. valid is a single
// cycle pulse with no backpressure; the response fields change only on the
// edge that raises valid and hold until the next valid.
interface sm83_alu_nibble_seq_if #(
    parameter int WORD_SIZE = 8
);
    import sm83_alu_pkg::*;

    logic                 start;
    logic [4:0]           op;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic                 carry_in;
    logic                 half_carry_in;
    logic                 neg_in;

    logic                 busy;
    logic                 valid;
    logic [WORD_SIZE-1:0] result;
    logic                 result_we;
    logic                 zero_out;
    logic                 carry_out;
    logic                 half_carry_out;
    logic                 sign_out;
    logic                 shift_out;
    logic                 daa_carry_out;
    alu_state_t           dbg_state;

    modport master (
        output start, op, a, b, carry_in, half_carry_in, neg_in,
        input  busy, valid, result, result_we, zero_out, carry_out,
               half_carry_out, sign_out, shift_out, daa_carry_out, dbg_state
    );

    modport slave (
        input  start, op, a, b, carry_in, half_carry_in, neg_in,
        output busy, valid, result, result_we, zero_out, carry_out,
               half_carry_out, sign_out, shift_out, daa_carry_out, dbg_state
    );

endinterface

// File: rtl/sm83_alu_nibble_core.sv
// sm83_alu_nibble_core: combinational nibble-wide adder / logic unit.
//   mode - CORE_ADD (a + b + cin) or bitwise AND / XOR / OR
//   a, b - nibble operands
//   cin  - carry into the adder (ignored by logic modes)
//   y    - nibble result
//   cout - adder carry out; 0 for logic modes
module sm83_alu_nibble_core
    import sm83_alu_pkg::*;
#(
    parameter int NIBBLE_SIZE = 4
) (
    input  core_mode_t             mode,
    input  logic [NIBBLE_SIZE-1:0] a,
    input  logic [NIBBLE_SIZE-1:0] b,
    input  logic                   cin,
    output logic [NIBBLE_SIZE-1:0] y,
    output logic                   cout
);

    logic [NIBBLE_SIZE:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{NIBBLE_SIZE{1'b0}}, cin};
        y    = sum[NIBBLE_SIZE-1:0];
        cout = sum[NIBBLE_SIZE];
        case (mode)
            CORE_AND: begin y = a & b; cout = 1'b0; end
            CORE_XOR: begin y = a ^ b; cout = 1'b0; end
            CORE_OR:  begin y = a | b; cout = 1'b0; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// sm83_alu_nibble_seq: 8-bit SM83 ALU sequenced over one shared nibble core.
// The low nibble is computed in state LO, the high nibble in state HI, and
// the registered result and flag sources are presented with a valid pulse
// in the following cycle.
//   clk     - clock, all state on posedge
//   reset_n - asynchronous active-low reset
//   bus     - request/response bundle (slave side), see the interface file
module sm83_alu_nibble_seq
    import sm83_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    sm83_alu_nibble_seq_if.slave bus
);

    localparam int NIBBLE_SIZE = WORD_SIZE / 2;

    alu_state_t state, state_n;
    logic       accept;

    // Operation context captured at accept.
    alu_op_t              op_q;
    core_mode_t           mode_q;
    logic [WORD_SIZE-1:0] a_q, b_q;
    logic                 cin_q, shift_q, daac_q;

    // Low nibble results carried into the HI cycle.
    logic [NIBBLE_SIZE-1:0] lo_q;
    logic                   hc_q;

    // Pre-mux: everything is reduced to "core(a', b', cin)" before capture,
    // so LO/HI only ever run the core on the latched operands.
    alu_op_t              op_dec;
    core_mode_t           pre_mode;
    logic [WORD_SIZE-1:0] pre_a, pre_b, daa_adj;
    logic                 pre_cin, pre_shift, pre_daa_c;

    always_comb begin
        op_dec    = decode_op(bus.op);
        pre_mode  = CORE_ADD;
        pre_a     = bus.a;
        pre_b     = bus.b;
        pre_cin   = 1'b0;
        pre_shift = 1'b0;
        pre_daa_c = 1'b0;
        daa_adj   = '0;
        case (op_dec)
            OP_ADC: pre_cin = bus.carry_in;
            // Subtraction as a + ~b + 1 (- carry); the adder carries become
            // "no borrow" and are inverted again on the way out.
            OP_SUB, OP_CP: begin pre_b = ~bus.b; pre_cin = 1'b1; end
            OP_SBC:        begin pre_b = ~bus.b; pre_cin = ~bus.carry_in; end
            OP_AND: pre_mode = CORE_AND;
            OP_XOR: pre_mode = CORE_XOR;
            OP_OR:  pre_mode = CORE_OR;
            // Shifts are formed here and passed through the core as a + 0.
            OP_RLC: begin
                pre_a = {bus.a[WORD_SIZE-2:0], bus.a[WORD_SIZE-1]};
                pre_b = '0; pre_shift = bus.a[WORD_SIZE-1];
            end
            OP_RRC: begin
                pre_a = {bus.a[0], bus.a[WORD_SIZE-1:1]};
                pre_b = '0; pre_shift = bus.a[0];
            end
            OP_RL: begin
                pre_a = {bus.a[WORD_SIZE-2:0], bus.carry_in};
                pre_b = '0; pre_shift = bus.a[WORD_SIZE-1];
            end
            OP_RR: begin
                pre_a = {bus.carry_in, bus.a[WORD_SIZE-1:1]};
                pre_b = '0; pre_shift = bus.a[0];
            end
            OP_SLA: begin
                pre_a = {bus.a[WORD_SIZE-2:0], 1'b0};
                pre_b = '0; pre_shift = bus.a[WORD_SIZE-1];
            end
            OP_SRA: begin
                pre_a = {bus.a[WORD_SIZE-1], bus.a[WORD_SIZE-1:1]};
                pre_b = '0; pre_shift = bus.a[0];
            end
            OP_SRL: begin
                pre_a = {1'b0, bus.a[WORD_SIZE-1:1]};
                pre_b = '0; pre_shift = bus.a[0];
            end
            OP_SWAP: begin
                pre_a = {bus.a[NIBBLE_SIZE-1:0], bus.a[WORD_SIZE-1:NIBBLE_SIZE]};
                pre_b = '0;
            end
            // After a subtraction only the incoming flags select the
            // correction; after an addition the value itself also does.
            OP_DAA: begin
                if (bus.carry_in || (!bus.neg_in && bus.a > WORD_SIZE'(8'h99))) begin
                    daa_adj   = daa_adj | WORD_SIZE'(DAA_ADJ_HI);
                    pre_daa_c = 1'b1;
                end
                if (bus.half_carry_in ||
                    (!bus.neg_in && bus.a[NIBBLE_SIZE-1:0] > NIBBLE_SIZE'(9))) begin
                    daa_adj = daa_adj | WORD_SIZE'(DAA_ADJ_LO);
                end
                pre_b   = bus.neg_in ? ~daa_adj : daa_adj;
                pre_cin = bus.neg_in;
            end
            default: ;
        endcase
    end

    // Shared core: low nibble with the entry carry, high nibble with hc.
    logic [NIBBLE_SIZE-1:0] core_a, core_b, core_y;
    logic                   core_cin, core_co;

    assign core_a   = (state == HI) ? a_q[WORD_SIZE-1:NIBBLE_SIZE] : a_q[NIBBLE_SIZE-1:0];
    assign core_b   = (state == HI) ? b_q[WORD_SIZE-1:NIBBLE_SIZE] : b_q[NIBBLE_SIZE-1:0];
    assign core_cin = (state == HI) ? hc_q : cin_q;

    sm83_alu_nibble_core #(
        .NIBBLE_SIZE(NIBBLE_SIZE)
    ) u_core (
        .mode (mode_q),
        .a    (core_a),
        .b    (core_b),
        .cin  (core_cin),
        .y    (core_y),
        .cout (core_co)
    );

    // Post-mux: final value and flags, valid during HI.
    logic [WORD_SIZE-1:0] fin_res;
    logic                 fin_c, fin_h;

    always_comb begin
        fin_res = {core_y, lo_q};
        fin_c   = 1'b0;
        fin_h   = 1'b0;
        case (op_q)
            OP_SUB, OP_SBC, OP_CP: begin fin_c = ~core_co; fin_h = ~hc_q; end
            OP_AND: fin_h = 1'b1;
            OP_XOR, OP_OR, OP_SWAP: ;
            OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: fin_c = shift_q;
            OP_DAA: fin_c = daac_q;
            default: begin fin_c = core_co; fin_h = hc_q; end
        endcase
    end

    // Sequencer.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin state_n = LO; accept = 1'b1; end
            LO:   state_n = HI;
            HI:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_ADD;
            mode_q  <= CORE_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            shift_q <= 1'b0;
            daac_q  <= 1'b0;
            lo_q    <= '0;
            hc_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_dec;
                mode_q  <= pre_mode;
                a_q     <= pre_a;
                b_q     <= pre_b;
                cin_q   <= pre_cin;
                shift_q <= pre_shift;
                daac_q  <= pre_daa_c;
            end
            if (state == LO) begin
                lo_q <= core_y;
                hc_q <= core_co;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.valid          <= 1'b0;
            bus.result         <= '0;
            bus.result_we      <= 1'b0;
            bus.zero_out       <= 1'b0;
            bus.carry_out      <= 1'b0;
            bus.half_carry_out <= 1'b0;
            bus.sign_out       <= 1'b0;
            bus.shift_out      <= 1'b0;
            bus.daa_carry_out  <= 1'b0;
        end else begin
            bus.valid <= (state == HI);
            if (state == HI) begin
                bus.result         <= fin_res;
                bus.result_we      <= (op_q != OP_CP);
                bus.zero_out       <= (fin_res == '0);
                bus.carry_out      <= fin_c;
                bus.half_carry_out <= fin_h;
                bus.sign_out       <= fin_res[WORD_SIZE-1];
                bus.shift_out      <= shift_q;
                bus.daa_carry_out  <= daac_q;
            end
        end
    end

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// tb_sm83_alu_nibble_seq: self-checking bench for sm83_alu_nibble_seq.
// Expected {result, we, Z, C, H, S, shift, daa_c} words are pushed when a
// request is accepted and popped when valid is seen.
module tb_sm83_alu_nibble_seq;
    import sm83_alu_pkg::*;

    localparam int W  = 8;
    localparam int EW = W + 7;

    logic clk = 1'b0;
    logic reset_n;

    sm83_alu_nibble_seq_if #(.WORD_SIZE(W)) bus ();

    sm83_alu_nibble_seq #(.WORD_SIZE(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic c,
                                            input logic h, input logic n);
        logic [W-1:0] r;
        logic cy, hc, sh, dc, we;
        int ai, bi, ci, adj, s;
        ai = int'(a); bi = int'(b);
        r = a; cy = 0; hc = 0; sh = 0; dc = 0; we = 1; ci = 0; adj = 0; s = 0;
        case (op)
            OP_SUB, OP_SBC, OP_CP: begin
                ci = (op == OP_SBC) ? int'(c) : 0;
                r  = W'(ai - bi - ci);
                cy = (ai < bi + ci);
                hc = ((ai & 15) < (bi & 15) + ci);
                we = (op != OP_CP);
            end
            OP_AND: begin r = a & b; hc = 1; end
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_RLC: begin sh = a[7]; r = {a[6:0], a[7]}; end
            OP_RRC: begin sh = a[0]; r = {a[0], a[7:1]}; end
            OP_RL:  begin sh = a[7]; r = {a[6:0], c}; end
            OP_RR:  begin sh = a[0]; r = {c, a[7:1]}; end
            OP_SLA: begin sh = a[7]; r = {a[6:0], 1'b0}; end
            OP_SRA: begin sh = a[0]; r = {a[7], a[7:1]}; end
            OP_SRL: begin sh = a[0]; r = {1'b0, a[7:1]}; end
            OP_SWAP: r = {a[3:0], a[7:4]};
            OP_DAA: begin
                if (!n) begin
                    if (c || ai > 'h99) begin adj += 'h60; dc = 1; end
                    if (h || (ai & 15) > 9) adj += 6;
                    r = W'(ai + adj);
                end else begin
                    if (c) adj += 'h60;
                    if (h) adj += 6;
                    dc = c;
                    r  = W'(ai - adj);
                end
                cy = dc;
            end
            default: begin
                ci = (op == OP_ADC) ? int'(c) : 0;
                s  = ai + bi + ci;
                r  = W'(s);
                cy = (s > 255);
                hc = ((ai & 15) + (bi & 15) + ci > 15);
            end
        endcase
        if (op >= OP_RLC && op <= OP_SRL) cy = sh;
        return {r, we, (r == 0), cy, hc, r[7], sh, dc};
    endfunction

    // ---------------- driver ----------------
    task automatic scramble_inputs();
        bus.op            = 5'($urandom_range(0, 31));
        bus.a             = W'($urandom);
        bus.b             = W'($urandom);
        bus.carry_in      = 1'($urandom);
        bus.half_carry_in = 1'($urandom);
        bus.neg_in        = 1'($urandom);
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic h, input logic n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", bus.busy, 0);
        bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
        bus.carry_in = c; bus.half_carry_in = h; bus.neg_in = n;
        exp_q.push_back(model(op, a, b, c, h, n));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.start = 0;
        // Operands must already be latched; disturb them.
        scramble_inputs();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] mon_e;
    int            mon_acc;

    always @(negedge clk) begin
        if (reset_n && bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", bus.valid, 0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                check("latency", cyc - mon_acc, 2);
                check("result", bus.result, mon_e[EW-1 -: W]);
                check("flags_we_z_c_h_s_sh_daa",
                      {bus.result_we, bus.zero_out, bus.carry_out, bus.half_carry_out,
                       bus.sign_out, bus.shift_out, bus.daa_carry_out},
                      mon_e[6:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int n_acc;

    initial begin
        reset_n = 0;
        bus.start = 0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.carry_in = 0; bus.half_carry_in = 0; bus.neg_in = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.result_we, bus.zero_out, bus.carry_out, bus.half_carry_out,
                            bus.sign_out, bus.shift_out, bus.daa_carry_out}, 0);
        check("rst_state", bus.dbg_state, IDLE);
        reset_n = 1;

        // Directed cases.
        drive_op(OP_ADD,  8'h3A, 8'hC6, 0, 0, 0);
        drive_op(OP_SUB,  8'h3E, 8'h0F, 0, 0, 0);
        drive_op(OP_SBC,  8'h00, 8'h00, 1, 0, 0);
        drive_op(OP_CP,   8'h3C, 8'h3C, 0, 0, 0);
        drive_op(OP_DAA,  8'h7D, 8'h00, 0, 0, 0);
        drive_op(OP_DAA,  8'h9A, 8'h00, 0, 0, 0);
        drive_op(OP_DAA,  8'h0F, 8'h00, 0, 1, 1);
        drive_op(OP_RR,   8'h01, 8'h00, 0, 0, 0);
        drive_op(OP_SWAP, 8'hF0, 8'h00, 0, 0, 0);
        drive_op(OP_AND,  8'hF0, 8'h0F, 0, 0, 0);
        drive_op(OP_ADC,  8'hFF, 8'h00, 1, 0, 0);
        drive_op(OP_RL,   8'h80, 8'h00, 1, 0, 0);
        drive_op(5'd25,   8'h0F, 8'h01, 1, 0, 0);
        drain();

        // Random ops over all encodings, including undefined ones.
        for (int i = 0; i < 40; i++) begin
            drive_op(5'($urandom_range(0, 31)), W'($urandom), W'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // start held high with a new op every cycle.
        n_acc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            scramble_inputs();
            bus.start = 1;
            if (!bus.busy) begin
                exp_q.push_back(model(bus.op, bus.a, bus.b, bus.carry_in,
                                      bus.half_carry_in, bus.neg_in));
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
        end
        @(negedge clk);
        bus.start = 0;
        check("b2b_accepts", n_acc, 5);
        drain();

        // Reset asserted while in HI.
        drive_op(OP_OR, 8'h5A, 8'h81, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("hi_state", bus.dbg_state, HI);
        check("hi_busy", bus.busy, 1);
        reset_n = 0;
        #1;
        check("midop_rst_busy", bus.busy, 0);
        check("midop_rst_valid", bus.valid, 0);
        check("midop_rst_result", bus.result, 0);
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(negedge clk);
        check("rst_hold_valid", bus.valid, 0);
        reset_n = 1;
        drive_op(OP_XOR, 8'hA5, 8'h0F, 0, 0, 0);
        drive_op(OP_SRA, 8'h81, 8'h00, 0, 0, 0);
        drain();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
